// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with one shared period counter.
// Supports edge-aligned and center-aligned counting. Duty levels, period and
// mode are double-buffered and only change at a period boundary (wrap), so an
// output never glitches in the middle of a period.
module pwm_multi #(
    parameter int WIDTH = 8,
    parameter int NCH   = 3,
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             center,
    input  logic [WIDTH-1:0] period,
    input  logic             wr_en,
    input  logic [CW-1:0]    wr_ch,
    input  logic [WIDTH-1:0] wr_level,
    output logic [NCH-1:0]   out,
    output logic             period_start
);

    localparam logic [0:0] DIR_UP   = 1'b0;
    localparam logic [0:0] DIR_DOWN = 1'b1;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt;
    logic [0:0]       dir;
    logic [WIDTH-1:0] p_act;
    logic             mode_act;
    logic [WIDTH-1:0] shadow [NCH];
    logic [WIDTH-1:0] active [NCH];
    logic             wrap;

    // Detect the last count state of the current period (the cycle before the counter restarts).
    // A center-aligned period with P==1 is just 0,1, so it ends on the way up.
    always_comb begin
        wrap = 1'b0;
        if (!mode_act) begin
            wrap = (cnt == p_act);
        end else if (p_act == '0) begin
            wrap = 1'b1;
        end else if (dir == DIR_DOWN) begin
            wrap = (cnt == ONE);
        end else begin
            wrap = (p_act == ONE) && (cnt == p_act);
        end
    end

    // Shadow level registers; writes to a channel index beyond NCH-1 match no entry and are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_en && (wr_ch == CW'(i))) begin
                    shadow[i] <= wr_level;
                end
            end
        end
    end

    // Period counter and buffered settings; when idle or at a wrap, the counter restarts and settings reload.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            dir      <= DIR_UP;
            p_act    <= '0;
            mode_act <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                active[i] <= '0;
            end
        end else if (!enable || wrap) begin
            cnt      <= '0;
            dir      <= DIR_UP;
            p_act    <= period;
            mode_act <= center;
            for (int i = 0; i < NCH; i++) begin
                active[i] <= shadow[i];
            end
        end else if (!mode_act) begin
            cnt <= cnt + ONE;
        end else if (dir == DIR_UP) begin
            if (cnt == p_act) begin
                dir <= DIR_DOWN;
                cnt <= cnt - ONE;
            end else begin
                cnt <= cnt + ONE;
            end
        end else begin
            cnt <= cnt - ONE;
        end
    end

    // Registered outputs: compare the count against each active level and flag the period start.
    always_ff @(posedge clk) begin
        if (reset) begin
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                out[i] <= enable && (cnt < active[i]);
            end
            period_start <= enable && (cnt == '0) && (dir == DIR_UP);
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed scoreboard bench for pwm_multi (WIDTH=8, NCH=3).
// The stimulus process pushes a hand-derived expected output for every clock
// edge it drives; an independent monitor pops one entry per cycle on the
// falling edge and compares it with the DUT outputs.
module tb_pwm_multi;

    typedef struct {
        string      name;
        logic [2:0] out;
        logic       ps;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       center;
    logic [7:0] period;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_level;
    logic [2:0] out;
    logic       period_start;

    exp_t sb[$];
    int   tests;
    int   fails;

    pwm_multi #(
        .WIDTH(8),
        .NCH  (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .center      (center),
        .period      (period),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_level    (wr_level),
        .out         (out),
        .period_start(period_start)
    );

    // Free-running 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired tests=%0d fails=%0d", tests, fails);
        $fatal(1, "[TB] watchdog");
    end

    // Compare one scoreboard entry against the current DUT outputs
    task automatic checkOutput(input exp_t e);
        tests++;
        if (out !== e.out) begin
            fails++;
            $display("[TB] FAIL %s out: got %b expected %b at %0t", e.name, out, e.out, $time);
        end
        tests++;
        if (period_start !== e.ps) begin
            fails++;
            $display("[TB] FAIL %s period_start: got %b expected %b at %0t", e.name, period_start, e.ps, $time);
        end
    endtask

    // Monitor: one expected entry per driven edge, checked mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            checkOutput(sb.pop_front());
        end
    end

    // Drive every DUT input for the next rising edge
    task automatic applyStimulus(input logic rst, input logic en, input logic cen,
                                 input logic [7:0] per, input logic we,
                                 input logic [1:0] ch, input logic [7:0] lvl);
        reset    = rst;
        enable   = en;
        center   = cen;
        period   = per;
        wr_en    = we;
        wr_ch    = ch;
        wr_level = lvl;
    endtask

    // Let one rising edge happen and record what the outputs must be after it
    task automatic expectCycle(input string name, input logic [2:0] eo, input logic eps);
        exp_t e;
        @(posedge clk);
        e.name = name;
        e.out  = eo;
        e.ps   = eps;
        sb.push_back(e);
        #1;
    endtask

    initial begin
        int m;
        int c;
        int lvl0;
        tests = 0;
        fails = 0;

        // Reset: everything low
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 2'd0, 8'd0);
        expectCycle("reset", 3'b000, 1'b0);
        expectCycle("reset", 3'b000, 1'b0);

        // Load levels 3/0/10 and P=9 edge mode while idle
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd9, 1'b1, 2'd0, 8'd3);
        expectCycle("idle_wr", 3'b000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd9, 1'b1, 2'd1, 8'd0);
        expectCycle("idle_wr", 3'b000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd9, 1'b1, 2'd2, 8'd10);
        expectCycle("idle_wr", 3'b000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd9, 1'b0, 2'd0, 8'd0);
        expectCycle("idle_wr", 3'b000, 1'b0);

        // Edge mode, mid-period write (7 at cnt 4) and write on the wrap edge (5 at cnt 9)
        for (int j = 0; j < 60; j++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'd9, 1'b0, 2'd0, 8'd0);
            if (j == 24) applyStimulus(1'b0, 1'b1, 1'b0, 8'd9, 1'b1, 2'd0, 8'd7);
            if (j == 39) applyStimulus(1'b0, 1'b1, 1'b0, 8'd9, 1'b1, 2'd0, 8'd5);
            m    = j % 10;
            lvl0 = (j < 30) ? 3 : ((j < 50) ? 7 : 5);
            expectCycle("edge_p9", {1'b1, 1'b0, (m < lvl0)}, (m == 0));
        end

        // Switch inputs to center P=4, ch0=2; the running edge period finishes first
        for (int j = 60; j < 70; j++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 8'd4, (j == 60), 2'd0, 8'd2);
            m = j % 10;
            expectCycle("edge_tail", {1'b1, 1'b0, (m < 5)}, (m == 0));
        end

        // Center mode: count 0,1,2,3,4,3,2,1; later request P=0 edge with ch0=1
        for (int k = 0; k < 24; k++) begin
            if (k < 16) applyStimulus(1'b0, 1'b1, 1'b1, 8'd4, 1'b0, 2'd0, 8'd0);
            else        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, (k == 16), 2'd0, 8'd1);
            m = k % 8;
            c = (m <= 4) ? m : 8 - m;
            expectCycle("center_p4", {1'b1, 1'b0, (c < 2)}, (m == 0));
        end

        // P=0 edge: constant output and period_start; writes to channel 3 are dropped
        for (int k = 24; k < 32; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, (k == 24 || k == 25), 2'd3, 8'd0);
            expectCycle("p0_edge", 3'b101, 1'b1);
        end

        // Back to P=9: one more P=0 period, then count 0..4, reset lands at cnt 5
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd9, 1'b0, 2'd0, 8'd0);
        expectCycle("p9_restart", 3'b101, 1'b1);
        expectCycle("p9_restart", 3'b101, 1'b1);
        for (int k = 0; k < 4; k++) begin
            expectCycle("p9_count", 3'b100, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd9, 1'b0, 2'd0, 8'd0);
        expectCycle("mid_reset", 3'b000, 1'b0);
        expectCycle("mid_reset", 3'b000, 1'b0);

        // Idle four cycles, then run: cleared levels give all-low outputs
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd9, 1'b0, 2'd0, 8'd0);
        for (int k = 0; k < 4; k++) begin
            expectCycle("post_reset_idle", 3'b000, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd9, 1'b0, 2'd0, 8'd0);
        for (int k = 0; k < 10; k++) begin
            expectCycle("cleared_run", 3'b000, (k == 0));
        end

        // Idle again with new levels 4/9/2 and P=5; first enabled period uses them
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd5, 1'b1, 2'd0, 8'd4);
        expectCycle("idle_wr2", 3'b000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd5, 1'b1, 2'd1, 8'd9);
        expectCycle("idle_wr2", 3'b000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd5, 1'b1, 2'd2, 8'd2);
        expectCycle("idle_wr2", 3'b000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 2'd0, 8'd0);
        expectCycle("idle_wr2", 3'b000, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd5, 1'b0, 2'd0, 8'd0);
        for (int k = 0; k < 12; k++) begin
            m = k % 6;
            expectCycle("edge_p5", {(m < 2), 1'b1, (m < 4)}, (m == 0));
        end

        // Disable drops outputs on the next edge
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 2'd0, 8'd0);
        expectCycle("disable", 3'b000, 1'b0);

        repeat (3) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
